// File: rtl/bank_reader_pkg.sv
// Shared definitions for the bank reader: FSM encoding and the address/count
// widths also used by the write side that fills the banks.
package bank_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int DEFAULT_BLOCK_DEPTH = 480;
    localparam int ADDR_W              = $clog2(DEFAULT_BLOCK_DEPTH);
    localparam int COUNT_W             = $clog2(DEFAULT_BLOCK_DEPTH + 1);

    // Width of an index over n items, never narrower than one bit.
    function automatic int index_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bank_reader_batch_serializer.sv
// Holds one RAM word per channel and presents it one byte (pixel) at a time,
// byte 0 first, under a valid/ready handshake.
module bank_reader_batch_serializer
    import bank_reader_pkg::*;
#(
    parameter int CHANNEL_COUNT = 3,
    parameter int BATCH_SIZE    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    load_i,
    input  logic [8*BATCH_SIZE-1:0] load_data_i [CHANNEL_COUNT],
    input  logic                    ready_i,
    output logic                    valid_o,
    output logic                    last_o,
    output logic [7:0]              pixel_o [CHANNEL_COUNT]
);

    localparam int IW = index_bits(BATCH_SIZE);
    localparam logic [IW-1:0] LAST_IDX = IW'(BATCH_SIZE - 1);

    logic [BATCH_SIZE-1:0][7:0] stream_q [CHANNEL_COUNT];
    logic [IW-1:0]              idx_q;
    logic                       valid_q;

    assign valid_o = valid_q;
    assign last_o  = valid_q && (idx_q == LAST_IDX);

    always_comb begin
        for (int c = 0; c < CHANNEL_COUNT; c++) begin
            pixel_o[c] = stream_q[c][idx_q];
        end
    end

    // A load always wins: the owner only loads when the register is empty or
    // its final byte is leaving this very cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < CHANNEL_COUNT; c++) begin
                stream_q[c] <= '0;
            end
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            for (int c = 0; c < CHANNEL_COUNT; c++) begin
                stream_q[c] <= load_data_i[c];
            end
            idx_q   <= '0;
            valid_q <= 1'b1;
        end else if (valid_q && ready_i) begin
            if (idx_q == LAST_IDX) begin
                idx_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bank_reader.sv
// Reads a run of words from the colour banks and streams them out as pixels,
// keeping one word streaming and one prefetched so transfers run back to back.
module bank_reader
    import bank_reader_pkg::*;
#(
    parameter int CHANNEL_COUNT = 3,
    parameter int BATCH_SIZE    = 16,
    parameter int BLOCK_DEPTH   = DEFAULT_BLOCK_DEPTH,
    parameter int READ_LATENCY  = 2
) (
    input  logic                             I_clk,
    input  logic                             I_rst,
    input  logic                             I_start,
    input  logic [$clog2(BLOCK_DEPTH)-1:0]   I_base_address,
    input  logic [$clog2(BLOCK_DEPTH+1)-1:0] I_batch_count,
    output logic [$clog2(BLOCK_DEPTH)-1:0]   O_ram_address,
    output logic                             O_ram_ce,
    input  logic [8*BATCH_SIZE-1:0]          I_ram_data [CHANNEL_COUNT],
    output logic [7:0]                       O_pixel [CHANNEL_COUNT],
    output logic                             O_pixel_valid,
    input  logic                             I_pixel_ready,
    output logic                             O_busy,
    output logic                             O_done,
    output state_t                           O_state
);

    localparam int AW = $clog2(BLOCK_DEPTH);
    localparam int CW = $clog2(BLOCK_DEPTH + 1);
    localparam int WW = 8 * BATCH_SIZE;
    localparam logic [AW-1:0] LAST_ADDR = AW'(BLOCK_DEPTH - 1);

    state_t                  state_q;
    logic [AW-1:0]           addr_q;
    logic [CW-1:0]           remain_q;
    logic                    ce_q;
    logic [READ_LATENCY-1:0] inflight_q;
    logic [WW-1:0]           pf_q [CHANNEL_COUNT];
    logic                    pf_full_q;
    logic                    done_q;

    logic                    s_valid;
    logic                    s_last;
    logic                    s_load;
    logic [WW-1:0]           s_load_data [CHANNEL_COUNT];
    logic                    last_xfer;
    logic                    data_ret;
    logic                    reload;
    logic                    load_ram;
    logic                    to_pf;
    logic                    start_issue;
    logic                    run_issue;
    logic                    issue;
    logic                    final_xfer;
    logic [READ_LATENCY-1:0] inflight_d;
    logic [AW-1:0]           addr_next;

    // Handshake: a pixel moves when O_pixel_valid and I_pixel_ready are both
    // high at a rising edge; while valid is high without ready, O_pixel and
    // O_pixel_valid hold, and valid never drops before its transfer.
    always_comb begin
        last_xfer   = s_valid && I_pixel_ready && s_last;
        data_ret    = inflight_q[READ_LATENCY-1];
        reload      = last_xfer && pf_full_q;
        load_ram    = data_ret && !pf_full_q && (!s_valid || last_xfer);
        to_pf       = data_ret && !load_ram;
        s_load      = reload || load_ram;
        start_issue = (state_q == ST_IDLE) && I_start && (I_batch_count != '0);
        // One read at a time, and only when its word has somewhere to land.
        run_issue   = (state_q == ST_RUN) && (remain_q != '0) &&
                      (inflight_q == '0) && (!pf_full_q || reload);
        issue       = start_issue || run_issue;
        final_xfer  = (state_q == ST_DRAIN) && last_xfer && !pf_full_q &&
                      (inflight_q == '0);
        inflight_d    = inflight_q << 1;
        inflight_d[0] = issue;
        addr_next   = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
        for (int c = 0; c < CHANNEL_COUNT; c++) begin
            s_load_data[c] = reload ? pf_q[c] : I_ram_data[c];
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            ce_q       <= 1'b0;
            inflight_q <= '0;
            pf_full_q  <= 1'b0;
            done_q     <= 1'b0;
            for (int c = 0; c < CHANNEL_COUNT; c++) begin
                pf_q[c] <= '0;
            end
        end else begin
            ce_q       <= issue;
            inflight_q <= inflight_d;
            done_q     <= 1'b0;
            if (ce_q) begin
                addr_q <= addr_next;
            end
            if (to_pf) begin
                for (int c = 0; c < CHANNEL_COUNT; c++) begin
                    pf_q[c] <= I_ram_data[c];
                end
                pf_full_q <= 1'b1;
            end else if (reload) begin
                pf_full_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (I_start) begin
                        if (I_batch_count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            // The first read goes out straight from the start edge.
                            addr_q   <= I_base_address;
                            remain_q <= I_batch_count - 1'b1;
                            state_q  <= (I_batch_count == CW'(1)) ? ST_DRAIN : ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (run_issue) begin
                        remain_q <= remain_q - 1'b1;
                        if (remain_q == CW'(1)) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (final_xfer) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    bank_reader_batch_serializer #(
        .CHANNEL_COUNT (CHANNEL_COUNT),
        .BATCH_SIZE    (BATCH_SIZE)
    ) u_serializer (
        .clk_i       (I_clk),
        .rst_i       (I_rst),
        .load_i      (s_load),
        .load_data_i (s_load_data),
        .ready_i     (I_pixel_ready),
        .valid_o     (s_valid),
        .last_o      (s_last),
        .pixel_o     (O_pixel)
    );

    assign O_ram_address = addr_q;
    assign O_ram_ce      = ce_q;
    assign O_pixel_valid = s_valid;
    assign O_busy        = (state_q != ST_IDLE);
    assign O_done        = done_q;
    assign O_state       = state_q;

endmodule

// File: doc/bank_reader.md
BANK_READER -- requirements
Module: Bank_Reader

Interface
REQ-001 SHALL have parameter CHANNEL_COUNT, default 3, number of colour channels.
REQ-002 SHALL have parameter BATCH_SIZE, default 16, pixels per RAM word.
REQ-003 SHALL have parameter BLOCK_DEPTH, default 480, words per bank.
REQ-004 SHALL have parameter READ_LATENCY, default 2, cycles from O_ram_ce to valid I_ram_data (legal range 1..4).
REQ-005 SHALL have port I_clk, input, 1, single clock; one clock, reset asynchronous active-high.
REQ-006 SHALL have port I_rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port I_start, input, 1, one-cycle request pulse.
REQ-008 SHALL have port I_base_address, input, $clog2(BLOCK_DEPTH), first word address.
REQ-009 SHALL have port I_batch_count, input, $clog2(BLOCK_DEPTH+1), words to read per channel.
REQ-010 SHALL have port O_ram_address, output, $clog2(BLOCK_DEPTH), read address shared by all banks.
REQ-011 SHALL have port O_ram_ce, output, 1, read enable.
REQ-012 SHALL have port I_ram_data, input, 8*BATCH_SIZE x CHANNEL_COUNT (unpacked), bank read data.
REQ-013 SHALL have port O_pixel, output, 8 x CHANNEL_COUNT (unpacked), current pixel colours.
REQ-014 SHALL have ports O_pixel_valid (output, 1) and I_pixel_ready (input, 1), valid/ready handshake.
REQ-015 SHALL have ports O_busy (output, 1, request active) and O_done (output, 1, one-cycle completion pulse).

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN.
REQ-017 IDLE -> RUN on I_start with I_batch_count > 0; latch address and count.
REQ-018 I_start with I_batch_count = 0 SHALL pulse O_done next cycle, remain IDLE, issue no read.
REQ-019 I_start while not IDLE SHALL be ignored.
REQ-020 Two word buffers: stream register (being output) and prefetch register.
REQ-021 In RUN, a read SHALL be issued (O_ram_ce=1 one cycle) when words remain and no read is in flight and prefetch register is empty or will be consumed at or before data return.
REQ-022 Read data SHALL be captured exactly READ_LATENCY cycles after O_ram_ce, tracked by a READ_LATENCY-bit shift register.
REQ-023 Address SHALL increment after each read, wrapping BLOCK_DEPTH-1 -> 0.
REQ-024 Pixel k of a word (k = 0..BATCH_SIZE-1) SHALL be byte [8k+7:8k] of each channel; byte 0 output first.
REQ-025 Transfer occurs when O_pixel_valid and I_pixel_ready; O_pixel and O_pixel_valid SHALL hold while valid and not ready.
REQ-026 On transfer of pixel BATCH_SIZE-1, stream register SHALL reload from prefetch in the same cycle (no bubble) if prefetch full, else O_pixel_valid deasserts.
REQ-027 Returning data SHALL load stream register directly when it is empty, else prefetch register.
REQ-028 When all words read, RUN -> DRAIN; DRAIN -> IDLE on final pixel transfer, with O_done pulsed that cycle + 1.
REQ-029 O_busy SHALL be 1 in RUN and DRAIN, 0 in IDLE.
REQ-030 Sustained I_pixel_ready=1 SHALL yield exactly I_batch_count*BATCH_SIZE consecutive transfers after initial fill (READ_LATENCY+1 cycles from I_start to first valid).

Reset
REQ-031 On I_rst, asynchronously: state IDLE, O_ram_ce 0, O_ram_address 0, O_pixel all 0, O_pixel_valid 0, O_busy 0, O_done 0, buffers empty, in-flight tracker cleared.
REQ-032 Reset mid-request SHALL abort it; late I_ram_data SHALL be ignored; no O_done.

Structure
REQ-033 Shared package SHALL hold state enum and width constants (address, count widths) shared with Input_Logic write side.
REQ-034 One sub-module Batch_Serializer SHALL hold stream register and byte index, exposing load/valid/ready/last.

Verification
REQ-035 Base 0, count 2, ready=1, RAM byte k = k: O_pixel sequence 0..15,0..15 on all channels, 32 consecutive transfers, O_done once.
REQ-036 Base 479, count 3: addresses 479,0,1 issued.
REQ-037 Ready toggling 1/0 each cycle, count 4: 64 transfers, outputs stable when ready=0, no lost or duplicated byte.
REQ-038 Ready=0 for 100 cycles after first valid: at most 2 reads issued, O_pixel held at byte 0.
REQ-039 Count 0: O_done one cycle after I_start, O_ram_ce never asserted; I_start during busy ignored.
REQ-040 I_rst asserted mid-word, count 5: all outputs zero immediately; subsequent request with base 10 reads from address 10 correctly.
